divider_ctrl: RTL and testbench
===============================

DIVIDER_CTRL -- requirements
Module: divider_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; no other clock or reset inputs.
REQ-002 Parameter DIVZ_Q, default 16'hFFFF, SHALL be the quotient reported on divide-by-zero.
REQ-003 CLK  input  1  sole clock, all state updates on rising edge.
REQ-004 RST_N  input  1  asynchronous active-low reset.
REQ-005 BTN  input  2  debounced buttons; BTN[0] = start, BTN[1] = display toggle; not synchronous to CLK.
REQ-006 I_DIVIDEND  input  16  unsigned dividend, from switches.
REQ-007 I_DIVISOR  input  8  unsigned divisor, from switches.
REQ-008 O_QUOT  output  16  registered quotient.
REQ-009 O_REM  output  8  registered remainder.
REQ-010 O_DISP  output  16  O_QUOT when O_SEL=0, {8'h00,O_REM} when O_SEL=1.
REQ-011 O_SEL  output  1  display select.
REQ-012 O_BUSY  output  1  high while in RUN.
REQ-013 O_DONE  output  1  high while in DONE.
REQ-014 O_ERR  output  1  divide-by-zero flag for the last completed operation.

Function
REQ-015 Each BTN bit SHALL pass through a two-flop synchronizer (s1, s2) and a history flop (s3); press pulse = s2 & ~s3.
REQ-016 A BTN bit that rises before CLK edge k SHALL give a press pulse valid between edges k+1 and k+2, acted on at edge k+2; exactly one pulse per rising edge, none on falling edges or while held.
REQ-017 States: IDLE, RUN, DONE.
REQ-018 IDLE + start pulse, I_DIVISOR != 0: latch operands, clear 9-bit partial remainder and 5-bit counter, go RUN.
REQ-019 IDLE or DONE + start pulse, I_DIVISOR == 0: go DONE on the same edge; O_QUOT=DIVZ_Q, O_REM=8'h00, O_ERR=1.
REQ-020 RUN: restoring division, one quotient bit per edge, MSB first: P = {P[7:0], dividend bit}; if P >= {1'b0,divisor}, P -= divisor and bit=1, else bit=0.
REQ-021 RUN SHALL last exactly 16 edges; on the 16th edge (counter==15) O_QUOT and O_REM are written, O_ERR cleared, state goes DONE.
REQ-022 Start pulses during RUN SHALL be ignored; latched operands SHALL not follow switch changes during RUN.
REQ-023 DONE + start pulse SHALL behave as IDLE + start pulse (REQ-018/019); results hold until then.
REQ-024 O_QUOT/O_REM SHALL keep previous values during RUN; update only at RUN exit or divide-by-zero.
REQ-025 A BTN[1] press pulse SHALL toggle O_SEL in any state, including the same edge as a start pulse.
REQ-026 Arithmetic SHALL be unsigned; partial remainder 9 bits wide so no compare overflow at divisor=8'hFF.

Reset
REQ-027 RST_N low SHALL immediately force: state IDLE, O_QUOT=0, O_REM=0, O_SEL=0, O_BUSY=0, O_DONE=0, O_ERR=0, counter=0, synchronizer flops=0.
REQ-028 Reset asserted mid-RUN SHALL abort the operation with no result written; a BTN held high across reset release SHALL produce one start pulse after release.

Verification
REQ-029 Dividend 16'd1000, divisor 8'd7, press BTN[0] -> O_BUSY high 16 cycles, then O_DONE=1, O_QUOT=16'd142, O_REM=8'd6, O_ERR=0.
REQ-030 Dividend 16'hFFFF, divisor 8'hFF -> O_QUOT=16'h0101, O_REM=8'h00; divisor 8'd1 -> O_QUOT=16'hFFFF, O_REM=0.
REQ-031 Divisor 0, press BTN[0] -> O_DONE and O_ERR high 2 edges after the pulse edge (no RUN), O_QUOT=16'hFFFF, O_REM=0; next valid op clears O_ERR.
REQ-032 Second BTN[0] press and switch change during RUN -> ignored; result matches original operands.
REQ-033 Press BTN[1] after result 142 rem 6 -> O_DISP 16'd142 then 16'h0006, back to 16'd142 on next press; holding BTN[1] toggles once.
REQ-034 Assert RST_N low at RUN cycle 8 -> all outputs 0 asynchronously; after release, new op completes correctly.

Source files
------------

// File: rtl/divider_ctrl.sv
// rtl/divider_ctrl.sv - button-driven 16/8 unsigned restoring divider with display select
//
// Ports:
//   CLK        sole clock, rising edge
//   RST_N      asynchronous active-low reset
//   BTN[1:0]   debounced buttons, asynchronous to CLK; [0] start, [1] display toggle
//   I_DIVIDEND 16-bit unsigned dividend (switches)
//   I_DIVISOR  8-bit unsigned divisor (switches)
//   O_QUOT     registered quotient
//   O_REM      registered remainder
//   O_DISP     O_QUOT, or zero-extended O_REM when O_SEL is high
//   O_SEL      display select
//   O_BUSY     high while dividing
//   O_DONE     high while a result is being held
//   O_ERR      last completed operation was a divide-by-zero
module divider_ctrl #(
    parameter logic [15:0] DIVZ_Q = 16'hFFFF
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [1:0]  BTN,
    input  logic [15:0] I_DIVIDEND,
    input  logic [7:0]  I_DIVISOR,
    output logic [15:0] O_QUOT,
    output logic [7:0]  O_REM,
    output logic [15:0] O_DISP,
    output logic        O_SEL,
    output logic        O_BUSY,
    output logic        O_DONE,
    output logic        O_ERR
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [1:0]  s1, s2, s3;
    logic [1:0]  press;
    logic        load, divz, finish;

    // work shifts dividend bits out of the top while quotient bits enter at
    // the bottom, so after 16 steps it holds the quotient.
    logic [15:0] work;
    logic [7:0]  divisor_q;
    logic [7:0]  p;
    logic [4:0]  cnt;
    logic [8:0]  p_shift;
    logic        ge;
    logic [7:0]  p_new;

    // Two synchronizer flops plus one history flop per button.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1 <= 2'b00;
            s2 <= 2'b00;
            s3 <= 2'b00;
        end else begin
            s1 <= BTN;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign press = s2 & ~s3;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        divz      = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (press[0]) begin
                    if (I_DIVISOR == 8'h00) begin
                        divz      = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        load      = 1'b1;
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                if (cnt == 5'd15) begin
                    finish    = 1'b1;
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The stored remainder is always below the divisor, so 8 bits hold it;
    // only the shifted value needs the ninth bit for the compare, which keeps
    // divisor 8'hFF from overflowing.
    assign p_shift = {p, work[15]};
    assign ge      = (p_shift >= {1'b0, divisor_q});
    assign p_new   = ge ? (p_shift[7:0] - divisor_q) : p_shift[7:0];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            work      <= 16'h0000;
            divisor_q <= 8'h00;
            p         <= 8'h00;
            cnt       <= 5'd0;
            O_QUOT    <= 16'h0000;
            O_REM     <= 8'h00;
            O_ERR     <= 1'b0;
            O_SEL     <= 1'b0;
        end else begin
            if (load) begin
                work      <= I_DIVIDEND;
                divisor_q <= I_DIVISOR;
                p         <= 8'h00;
                cnt       <= 5'd0;
            end else if (state == RUN) begin
                work <= {work[14:0], ge};
                p    <= p_new;
                cnt  <= cnt + 5'd1;
            end
            if (finish) begin
                O_QUOT <= {work[14:0], ge};
                O_REM  <= p_new;
                O_ERR  <= 1'b0;
            end
            if (divz) begin
                O_QUOT <= DIVZ_Q;
                O_REM  <= 8'h00;
                O_ERR  <= 1'b1;
            end
            if (press[1]) O_SEL <= ~O_SEL;
        end
    end

    assign O_BUSY = (state == RUN);
    assign O_DONE = (state == DONE);
    assign O_DISP = O_SEL ? {8'h00, O_REM} : O_QUOT;

endmodule

// File: tb/tb_divider_ctrl.sv
// tb/tb_divider_ctrl.sv - directed self-checking bench for divider_ctrl
module tb_divider_ctrl;

    logic        CLK;
    logic        RST_N;
    logic [1:0]  BTN;
    logic [15:0] I_DIVIDEND;
    logic [7:0]  I_DIVISOR;
    logic [15:0] O_QUOT;
    logic [7:0]  O_REM;
    logic [15:0] O_DISP;
    logic        O_SEL;
    logic        O_BUSY;
    logic        O_DONE;
    logic        O_ERR;

    int tests_run;
    int tests_failed;

    divider_ctrl #(.DIVZ_Q(16'hFFFF)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .BTN        (BTN),
        .I_DIVIDEND (I_DIVIDEND),
        .I_DIVISOR  (I_DIVISOR),
        .O_QUOT     (O_QUOT),
        .O_REM      (O_REM),
        .O_DISP     (O_DISP),
        .O_SEL      (O_SEL),
        .O_BUSY     (O_BUSY),
        .O_DONE     (O_DONE),
        .O_ERR      (O_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Press start, check RUN length and the result.
    task automatic run_op(input string tag, input logic [15:0] dvd, input logic [7:0] dvs,
                          input logic [15:0] exp_q, input logic [7:0] exp_r,
                          input logic [15:0] prev_q);
        int busy_cnt;
        I_DIVIDEND = dvd;
        I_DIVISOR  = dvs;
        BTN[0]     = 1'b1;
        step();
        step();
        check({tag, "_not_yet_busy"}, 32'(O_BUSY), 32'd0);
        step();
        check({tag, "_busy"}, 32'(O_BUSY), 32'd1);
        check({tag, "_quot_held"}, 32'(O_QUOT), 32'(prev_q));
        BTN[0]   = 1'b0;
        busy_cnt = 1;
        while (O_BUSY && busy_cnt < 40) begin
            step();
            if (O_BUSY) busy_cnt++;
        end
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd16);
        check({tag, "_done"}, 32'(O_DONE), 32'd1);
        check({tag, "_quot"}, 32'(O_QUOT), 32'(exp_q));
        check({tag, "_rem"}, 32'(O_REM), 32'(exp_r));
        check({tag, "_err"}, 32'(O_ERR), 32'd0);
    endtask

    task automatic press_btn1();
        BTN[1] = 1'b1;
        step();
        step();
        step();
    endtask

    initial begin
        int guard;
        tests_run    = 0;
        tests_failed = 0;
        RST_N        = 1'b0;
        BTN          = 2'b00;
        I_DIVIDEND   = 16'd0;
        I_DIVISOR    = 8'd0;
        #3;
        check("rst_quot", 32'(O_QUOT), 32'd0);
        check("rst_rem", 32'(O_REM), 32'd0);
        check("rst_flags", 32'({O_SEL, O_BUSY, O_DONE, O_ERR}), 32'd0);
        step();
        step();
        RST_N = 1'b1;
        step();

        // Basic operation and 16-cycle RUN.
        run_op("d1000_7", 16'd1000, 8'd7, 16'd142, 8'd6, 16'd0);

        // Display toggle: single toggle while held, back on second press.
        check("disp_quot", 32'(O_DISP), 32'd142);
        press_btn1();
        check("disp_rem", 32'(O_DISP), 32'h0006);
        check("sel_one", 32'(O_SEL), 32'd1);
        repeat (5) step();
        check("disp_held", 32'(O_DISP), 32'h0006);
        BTN[1] = 1'b0;
        repeat (3) step();
        check("disp_release", 32'(O_DISP), 32'h0006);
        press_btn1();
        check("disp_back", 32'(O_DISP), 32'd142);
        BTN[1] = 1'b0;
        repeat (3) step();

        // Boundary divisors.
        run_op("dffff_ff", 16'hFFFF, 8'hFF, 16'h0101, 8'h00, 16'd142);
        run_op("dfffe_ff", 16'hFFFE, 8'hFF, 16'h0100, 8'hFE, 16'h0101);
        run_op("dffff_01", 16'hFFFF, 8'h01, 16'hFFFF, 8'h00, 16'h0100);
        repeat (3) step();

        // Divide by zero from DONE: result two edges after the pulse edge, no RUN.
        I_DIVIDEND = 16'd1234;
        I_DIVISOR  = 8'd0;
        BTN[0]     = 1'b1;
        step();
        step();
        check("divz_err_early", 32'(O_ERR), 32'd0);
        step();
        check("divz_err", 32'(O_ERR), 32'd1);
        check("divz_done", 32'(O_DONE), 32'd1);
        check("divz_busy", 32'(O_BUSY), 32'd0);
        check("divz_quot", 32'(O_QUOT), 32'hFFFF);
        check("divz_rem", 32'(O_REM), 32'd0);
        BTN[0] = 1'b0;
        repeat (3) step();
        run_op("d50_8", 16'd50, 8'd8, 16'd6, 8'd2, 16'hFFFF);
        repeat (3) step();

        // Second start and switch change during RUN are ignored.
        I_DIVIDEND = 16'd1000;
        I_DIVISOR  = 8'd7;
        BTN[0]     = 1'b1;
        repeat (3) step();
        BTN[0] = 1'b0;
        repeat (3) step();
        I_DIVIDEND = 16'd5000;
        I_DIVISOR  = 8'd3;
        BTN[0]     = 1'b1;
        repeat (3) step();
        BTN[0] = 1'b0;
        check("ign_busy", 32'(O_BUSY), 32'd1);
        guard = 0;
        while (O_BUSY && guard < 40) begin
            step();
            guard++;
        end
        check("ign_done", 32'(O_DONE), 32'd1);
        check("ign_quot", 32'(O_QUOT), 32'd142);
        check("ign_rem", 32'(O_REM), 32'd6);
        repeat (3) step();

        // Reset at RUN cycle 8 with start held across release.
        I_DIVIDEND = 16'd50003;
        I_DIVISOR  = 8'd200;
        BTN[0]     = 1'b1;
        repeat (3) step();
        repeat (7) step();
        check("mid_busy", 32'(O_BUSY), 32'd1);
        RST_N = 1'b0;
        #1;
        check("mid_rst_quot", 32'(O_QUOT), 32'd0);
        check("mid_rst_rem", 32'(O_REM), 32'd0);
        check("mid_rst_disp", 32'(O_DISP), 32'd0);
        check("mid_rst_flags", 32'({O_SEL, O_BUSY, O_DONE, O_ERR}), 32'd0);
        step();
        step();
        RST_N = 1'b1;
        guard = 0;
        while (!O_DONE && guard < 60) begin
            step();
            guard++;
        end
        check("post_rst_done", 32'(O_DONE), 32'd1);
        check("post_rst_quot", 32'(O_QUOT), 32'd250);
        check("post_rst_rem", 32'(O_REM), 32'd3);
        repeat (5) step();
        check("post_rst_single", 32'({O_BUSY, O_DONE}), 32'b01);
        BTN[0] = 1'b0;
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
